// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline request/response and data-memory bus bundle for lsu_mem_ctrl.
// slave = the controller; master = the pipeline and memory side driving it.
interface lsu_mem_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  mem_op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [1:0]  err_cause_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_strb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  modport slave (
    input  req_valid_i, is_load_i, is_store_i, mem_op_i, addr_i, wdata_i, flush_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output req_ready_o, stall_o, done_o, rdata_o, err_o, err_cause_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_strb_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, is_load_i, is_store_i, mem_op_i, addr_i, wdata_i, flush_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  req_ready_o, stall_o, done_o, rdata_o, err_o, err_cause_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_strb_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: one request per accept, bus req/gnt then rvalid, 1-cycle done pulse.
// Latency: accept + REQ(until gnt) + WAIT(until rvalid) + RESP; pipeline stalled outside IDLE.

// Combinational lane packer: strobes, shifted store data, load extraction, misalign check.
module lsu_mem_pack (
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_misaligned,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [1:0]  w_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_lane = i_addr[1:0];
  assign w_byte = i_rdata[{w_lane, 3'b000} +: 8];
  assign w_half = i_rdata[{w_lane[1], 4'b0000} +: 16];

  always_comb begin
    o_addr       = {i_addr[31:2], 2'b00};
    o_we         = i_is_store;
    o_misaligned = (i_is_load || i_is_store) &&
                   ((i_op[1:0] == 2'b01 && w_lane[0]) ||
                    (i_op[1:0] == 2'b10 && w_lane != 2'b00));
    o_strb  = 4'b0000;
    o_wdata = '0;
    if (i_is_store) begin
      case (i_op[1:0])
        2'b00: begin
          o_strb  = 4'b0001 << w_lane;
          o_wdata = {24'h0, i_wdata[7:0]} << {w_lane, 3'b000};
        end
        2'b01: begin
          o_strb  = 4'b0011 << {w_lane[1], 1'b0};
          o_wdata = {16'h0, i_wdata[15:0]} << {w_lane[1], 4'b0000};
        end
        2'b10: begin
          o_strb  = 4'b1111;
          o_wdata = i_wdata;
        end
        default: begin
          o_strb  = 4'b0000;
          o_wdata = '0;
        end
      endcase
    end
  end

  // op[2] selects zero-extension
  always_comb begin
    case (i_op[1:0])
      2'b00:   o_rdata = {{24{~i_op[2] & w_byte[7]}}, w_byte};
      2'b01:   o_rdata = {{16{~i_op[2] & w_half[15]}}, w_half};
      2'b10:   o_rdata = i_rdata;
      default: o_rdata = '0;
    endcase
  end
endmodule

module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  lsu_mem_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_RESP} state_t;

  typedef struct packed {
    logic        is_load;
    logic        is_store;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [1:0] C_MISALIGN = 2'b00;
  localparam logic [1:0] C_BUS      = 2'b01;
  localparam logic [1:0] C_TIMEOUT  = 2'b10;
  localparam logic [1:0] C_ILLEGAL  = 2'b11;

  localparam int unsigned CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TMO_M1 = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_M1);

  state_t        r_state;
  state_t        w_state_nxt;
  req_t          r_req;
  req_t          w_in;
  req_t          w_src;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [1:0]    r_cause;

  logic          w_illegal;
  logic          w_tmo;
  logic          w_res_err;
  logic [1:0]    w_res_cause;
  logic [31:0]   w_res_rdata;

  logic          w_lsu_misaligned;
  logic          w_lsu_we;
  logic [31:0]   w_lsu_addr;
  logic [3:0]    w_lsu_strb;
  logic [31:0]   w_lsu_wdata;
  logic [31:0]   w_lsu_rdata;

  assign w_illegal = (bus.is_load_i == bus.is_store_i) || (bus.mem_op_i[1:0] == 2'b11);

  // Illegal ops reach the packer with both direction flags cleared
  always_comb begin
    w_in.is_load  = bus.is_load_i  & ~w_illegal;
    w_in.is_store = bus.is_store_i & ~w_illegal;
    w_in.op       = bus.mem_op_i;
    w_in.addr     = bus.addr_i;
    w_in.wdata    = bus.wdata_i;
  end

  // Live inputs classify in IDLE; captured copy keeps the bus stable afterwards
  assign w_src = (r_state == S_IDLE) ? w_in : r_req;

  lsu_mem_pack u_lsu (
    .i_is_load    (w_src.is_load),
    .i_is_store   (w_src.is_store),
    .i_op         (w_src.op),
    .i_addr       (w_src.addr),
    .i_wdata      (w_src.wdata),
    .i_rdata      (bus.mem_rdata_i),
    .o_misaligned (w_lsu_misaligned),
    .o_we         (w_lsu_we),
    .o_addr       (w_lsu_addr),
    .o_strb       (w_lsu_strb),
    .o_wdata      (w_lsu_wdata),
    .o_rdata      (w_lsu_rdata)
  );

  assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_cnt >= TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_res_err   = 1'b0;
    w_res_cause = C_MISALIGN;
    w_res_rdata = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          if (w_illegal) begin
            w_state_nxt = S_RESP;
            w_res_err   = 1'b1;
            w_res_cause = C_ILLEGAL;
          end else if (w_lsu_misaligned) begin
            w_state_nxt = S_RESP;
            w_res_err   = 1'b1;
            w_res_cause = C_MISALIGN;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A flush racing the grant still owes the bus a response
        if (bus.flush_i) begin
          w_state_nxt = bus.mem_gnt_i ? S_DRAIN : S_IDLE;
        end else if (bus.mem_gnt_i) begin
          w_state_nxt = S_WAIT;
        end else if (w_tmo) begin
          w_state_nxt = S_RESP;
          w_res_err   = 1'b1;
          w_res_cause = C_TIMEOUT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid_i) begin
          w_state_nxt = S_RESP;
          if (bus.mem_err_i) begin
            w_res_err   = 1'b1;
            w_res_cause = C_BUS;
          end else if (r_req.is_load) begin
            w_res_rdata = w_lsu_rdata;
          end
        end else if (bus.flush_i) begin
          w_state_nxt = S_DRAIN;
        end else if (w_tmo) begin
          w_state_nxt = S_RESP;
          w_res_err   = 1'b1;
          w_res_cause = C_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (bus.mem_rvalid_i || w_tmo) w_state_nxt = S_IDLE;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o = (r_state == S_IDLE);
    bus.stall_o     = (r_state != S_IDLE);
    bus.done_o      = (r_state == S_RESP);
    bus.mem_req_o   = (r_state == S_REQ);
    bus.mem_we_o    = (r_state == S_REQ) && w_lsu_we;
    bus.mem_addr_o  = (r_state == S_REQ) ? w_lsu_addr  : '0;
    bus.mem_strb_o  = (r_state == S_REQ) ? w_lsu_strb  : '0;
    bus.mem_wdata_o = (r_state == S_REQ) ? w_lsu_wdata : '0;
    bus.rdata_o     = r_rdata;
    bus.err_o       = r_err;
    bus.err_cause_o = r_cause;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req <= '0;
    end else if (r_state == S_IDLE && bus.req_valid_i) begin
      r_req <= w_in;
    end
  end

  // Held in IDLE so it is zero on the first REQ cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (r_state inside {S_REQ, S_WAIT, S_DRAIN}) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cause <= 2'b00;
    end else if (w_state_nxt == S_RESP) begin
      r_rdata <= w_res_rdata;
      r_err   <= w_res_err;
      r_cause <= w_res_cause;
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: vector table of single transactions plus
// hand-written timeout, flush, reset and race sequences.
module tb_lsu_mem_ctrl;
  localparam int TMO = 64;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        merr;
    logic        has_bus;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rdata_o;
    logic        err;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic ld, logic st, logic [2:0] op, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata, logic merr,
                              logic has_bus, logic we, logic [3:0] strb, logic [31:0] maddr,
                              logic [31:0] mwdata, logic [31:0] rdata_o, logic err,
                              logic [1:0] cause);
    vec_t v;
    v.ld = ld; v.st = st; v.op = op; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.merr = merr; v.has_bus = has_bus; v.we = we; v.strb = strb;
    v.maddr = maddr; v.mwdata = mwdata; v.rdata_o = rdata_o; v.err = err; v.cause = cause;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 of the next state.
  task automatic accept(input logic ld, input logic st, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bus.is_load_i   = ld;
    bus.is_store_i  = st;
    bus.mem_op_i    = op;
    bus.addr_i      = addr;
    bus.wdata_i     = wdata;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.addr_i      = 32'hFFFF_FFFF;
    bus.wdata_i     = 32'h5A5A_5A5A;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    bus.is_load_i   = v.ld;
    bus.is_store_i  = v.st;
    bus.mem_op_i    = v.op;
    bus.addr_i      = v.addr;
    bus.wdata_i     = v.wdata;
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d req_ready idle", i), bus.req_ready_o, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.addr_i      = 32'hFFFF_FFFF;
    bus.wdata_i     = 32'h5A5A_5A5A;
    if (v.has_bus) begin
      @(negedge clk);
      check($sformatf("v%0d mem_req", i), bus.mem_req_o, 1);
      check($sformatf("v%0d mem_we", i), bus.mem_we_o, v.we);
      check($sformatf("v%0d mem_addr", i), bus.mem_addr_o, v.maddr);
      check($sformatf("v%0d mem_strb", i), bus.mem_strb_o, v.strb);
      check($sformatf("v%0d mem_wdata", i), bus.mem_wdata_o, v.mwdata);
      bus.mem_gnt_i = 1'b1;
      @(posedge clk); #1;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = v.rdata;
      bus.mem_err_i    = v.merr;
      @(posedge clk); #1;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_err_i    = 1'b0;
    end
    @(negedge clk);
    check($sformatf("v%0d done", i), bus.done_o, 1);
    check($sformatf("v%0d req_ready in resp", i), bus.req_ready_o, 0);
    check($sformatf("v%0d mem_req in resp", i), bus.mem_req_o, 0);
    check($sformatf("v%0d rdata_o", i), bus.rdata_o, v.rdata_o);
    check($sformatf("v%0d err_o", i), bus.err_o, v.err);
    check($sformatf("v%0d err_cause", i), bus.err_cause_o, v.cause);
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("v%0d done pulse width", i), bus.done_o, 0);
    check($sformatf("v%0d req_ready after", i), bus.req_ready_o, 1);
    check($sformatf("v%0d rdata_o held", i), bus.rdata_o, v.rdata_o);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int seen;
    int ndone;
    n_cmp = 0;
    n_err = 0;

    //      ld st op      addr          wdata         rdata         me bus we strb     maddr         mwdata        rdata_o       err cause
    vecs[0]  = mk(1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h8012_3456, 0, 1, 0, 4'b0000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 0, 2'b00);
    vecs[1]  = mk(1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h8012_3456, 0, 1, 0, 4'b0000, 32'h0000_0100, 32'h0,        32'h0000_0080, 0, 2'b00);
    vecs[2]  = mk(1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 0, 1, 0, 4'b0000, 32'h0000_0100, 32'h0,        32'hFFFF_8001, 0, 2'b00);
    vecs[3]  = mk(1, 0, 3'b101, 32'h0000_0100, 32'h0,        32'h8001_F00F, 0, 1, 0, 4'b0000, 32'h0000_0100, 32'h0,        32'h0000_F00F, 0, 2'b00);
    vecs[4]  = mk(1, 0, 3'b010, 32'h0000_0204, 32'h0,        32'hDEAD_BEEF, 0, 1, 0, 4'b0000, 32'h0000_0204, 32'h0,        32'hDEAD_BEEF, 0, 2'b00);
    vecs[5]  = mk(0, 1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,       0, 1, 1, 4'b0010, 32'h0000_0300, 32'h0000_A500, 32'h0,        0, 2'b00);
    vecs[6]  = mk(0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,       0, 1, 1, 4'b1100, 32'h0000_0200, 32'hABCD_0000, 32'h0,        0, 2'b00);
    vecs[7]  = mk(0, 1, 3'b010, 32'h0000_040C, 32'hCAFE_F00D, 32'h0,       0, 1, 1, 4'b1111, 32'h0000_040C, 32'hCAFE_F00D, 32'h0,        0, 2'b00);
    vecs[8]  = mk(1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,         32'h0,        32'h0,        1, 2'b00);
    vecs[9]  = mk(0, 1, 3'b001, 32'h0000_0203, 32'h1111_2222, 32'h0,       0, 0, 0, 4'b0000, 32'h0,         32'h0,        32'h0,        1, 2'b00);
    vecs[10] = mk(1, 1, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,         32'h0,        32'h0,        1, 2'b11);
    vecs[11] = mk(0, 0, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,         32'h0,        32'h0,        1, 2'b11);
    vecs[12] = mk(1, 0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,         32'h0,        32'h0,        1, 2'b11);
    vecs[13] = mk(1, 0, 3'b010, 32'h0000_0500, 32'h0,        32'h1234_5678, 1, 1, 0, 4'b0000, 32'h0000_0500, 32'h0,       32'h0,        1, 2'b01);
    vecs[14] = mk(1, 0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 1, 0, 4'b0000, 32'h0000_0100, 32'h0,       32'h0000_007F, 0, 2'b00);

    bus.req_valid_i  = 1'b0;
    bus.is_load_i    = 1'b0;
    bus.is_store_i   = 1'b0;
    bus.mem_op_i     = 3'b000;
    bus.addr_i       = '0;
    bus.wdata_i      = '0;
    bus.flush_i      = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.mem_err_i    = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset req_ready", bus.req_ready_o, 1);
    check("reset stall", bus.stall_o, 0);
    check("reset done", bus.done_o, 0);
    check("reset mem_req", bus.mem_req_o, 0);
    check("reset mem_strb", bus.mem_strb_o, 0);
    check("reset rdata_o", bus.rdata_o, 0);
    check("reset err_o", bus.err_o, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Grant never arrives: timeout after TMO cycles of request
    accept(1, 0, 3'b010, 32'h0000_0600, 32'h0);
    cnt = 0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.done_o) begin
        seen = 1;
        break;
      end
      if (bus.mem_req_o) cnt++;
    end
    check("tmo done seen", seen, 1);
    check("tmo req cycles", cnt, TMO);
    check("tmo err_o", bus.err_o, 1);
    check("tmo cause", bus.err_cause_o, 2'b10);
    @(posedge clk); #1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h7777_7777;
    @(posedge clk); #1;
    bus.mem_rvalid_i = 1'b0;
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done_o || !bus.req_ready_o) ndone++;
    end
    check("stray rvalid ignored", ndone, 0);
    check("tmo cause held", bus.err_cause_o, 2'b10);
    @(posedge clk); #1;

    // Flush in WAIT, response three cycles later is drained silently
    accept(1, 0, 3'b010, 32'h0000_0700, 32'h0);
    bus.mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt_i = 1'b0;
    bus.flush_i   = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    ndone = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (bus.done_o || bus.req_ready_o || !bus.stall_o) ndone++;
      @(posedge clk); #1;
    end
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h1357_9BDF;
    @(negedge clk);
    if (bus.done_o) ndone++;
    check("drain busy no done", ndone, 0);
    @(posedge clk); #1;
    bus.mem_rvalid_i = 1'b0;
    @(negedge clk);
    check("drain req_ready after rvalid", bus.req_ready_o, 1);
    check("drain no done", bus.done_o, 0);
    @(posedge clk); #1;

    // Flush before grant: back to IDLE, no completion
    accept(1, 0, 3'b010, 32'h0000_0800, 32'h0);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("req flush ready", bus.req_ready_o, 1);
    check("req flush no done", bus.done_o, 0);
    check("req flush mem_req", bus.mem_req_o, 0);
    @(posedge clk); #1;

    // Flush and rvalid together in WAIT: response completes
    accept(1, 0, 3'b010, 32'h0000_0900, 32'h0);
    bus.mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0BAD_F00D;
    bus.flush_i      = 1'b1;
    @(posedge clk); #1;
    bus.mem_rvalid_i = 1'b0;
    bus.flush_i      = 1'b0;
    @(negedge clk);
    check("race done", bus.done_o, 1);
    check("race rdata", bus.rdata_o, 32'h0BAD_F00D);
    check("race err", bus.err_o, 0);
    @(posedge clk); #1;

    // Asynchronous reset mid-request
    accept(1, 0, 3'b010, 32'h0000_0A00, 32'h0);
    @(negedge clk);
    check("pre-reset mem_req", bus.mem_req_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset mem_req", bus.mem_req_o, 0);
    check("async reset stall", bus.stall_o, 0);
    check("async reset rdata_o", bus.rdata_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset ready", bus.req_ready_o, 1);
    check("post-reset mem_req", bus.mem_req_o, 0);
    @(posedge clk); #1;
    run_vec(100, vecs[6]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
